// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and op-legality helper for the ALU and its arbiter.
package alu_pkg;
    localparam int ALU_W = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // True for op codes the ALU actually implements.
    function automatic logic op_legal(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction
endpackage

// File: rtl/alu.sv
// 32-bit ADD/SUB ALU with zero flag; unsupported ops yield y=0 (zero=1).
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [3:0]       op,
    output logic [ALU_W-1:0] y,
    output logic             zero
);
    // Modulo-2^32 arithmetic; no carry or overflow outputs.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            default: y = '0;
        endcase
        zero = (y == '0);
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr (wrapping mod N) wins.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt
);
    logic [PW:0] w_idx;
    logic        w_found;

    // Rotating priority search; gnt stays zero when disabled or idle.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                w_idx = {1'b0, ptr} + (PW+1)'(k);
                if (w_idx >= (PW+1)'(N))
                    w_idx = w_idx - (PW+1)'(N);
                if (!w_found && req[w_idx[PW-1:0]]) begin
                    gnt[w_idx[PW-1:0]] = 1'b1;
                    w_found            = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU among NREQ requesters: round-robin issue, one op in
// flight, registered result returned over a per-requester valid/ready channel.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ALU_W-1:0] req_a,
    input  logic [NREQ*ALU_W-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [ALU_W-1:0]      rsp_y,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int PW = $clog2(NREQ);

    arb_state_e       r_state, w_state_nxt;
    logic [PW-1:0]    r_rr_ptr, r_owner;
    logic [ALU_W-1:0] r_a, r_b, r_y;
    logic [3:0]       r_op;
    logic             r_zero, r_err;

    logic             w_hs, w_slot_open, w_accept;
    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_gidx;
    logic [ALU_W-1:0] w_alu_y;
    logic             w_alu_zero;

    // Handshake only counts for the owner; other rsp_ready bits are ignored.
    assign w_hs        = (r_state == RESP) && rsp_ready[r_owner];
    assign w_slot_open = (r_state == IDLE) || w_hs;
    assign w_accept    = |w_gnt;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .en  (w_slot_open),
        .gnt (w_gnt)
    );

    // The ALU sees only the captured operands, never live requester inputs.
    alu u_alu (
        .a    (r_a),
        .b    (r_b),
        .op   (r_op),
        .y    (w_alu_y),
        .zero (w_alu_zero)
    );

    // One-hot grant to index.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_gnt[i]) w_gidx = PW'(i);
    end

    // Next-state: accept moves to EXEC, EXEC always completes in one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_hs) w_state_nxt = w_accept ? EXEC : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Capture operands/owner on accept, results at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_y      <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= req_a[w_gidx*ALU_W +: ALU_W];
                r_b      <= req_b[w_gidx*ALU_W +: ALU_W];
                r_op     <= req_op[w_gidx*4 +: 4];
                r_owner  <= w_gidx;
                r_rr_ptr <= (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + PW'(1);
            end
            if (r_state == EXEC) begin
                r_y    <= w_alu_y;
                r_zero <= w_alu_zero;
                r_err  <= !op_legal(r_op);
            end
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_owner) : '0;
    assign rsp_y     = r_y;
    assign rsp_zero  = r_zero;
    assign rsp_err   = r_err;
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with NREQ=3.
module tb_alu_share_arb;
    localparam int NREQ = 3;

    logic              clk, rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*32-1:0] req_a, req_b;
    logic [NREQ*4-1:0] req_op;
    logic [31:0]       rsp_y;
    logic              rsp_zero, rsp_err, busy;

    int checks   = 0;
    int failures = 0;

    alu_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %0s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_op[idx*4 +: 4]  = op;
        req_valid[idx]      = 1'b1;
    endtask

    // Wait (bounded) until requester idx is granted; called just after an edge.
    task automatic wait_grant(input int idx, input string tag);
        int n = 0;
        #1;
        while (req_ready[idx] !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(req_ready), 32'(1 << idx));
    endtask

    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] ey, input logic ez,
                         input logic ee, input string tag);
        set_req(idx, a, b, op);
        wait_grant(idx, {tag, "_grant"});
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        #1;
        chk({tag, "_exec_vld"}, 32'(rsp_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
        @(posedge clk); #1;
        chk({tag, "_rsp_vld"}, 32'(rsp_valid), 32'(1 << idx));
        chk({tag, "_y"}, rsp_y, ey);
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(ez));
        chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
        @(posedge clk); #1;
        chk({tag, "_done_vld"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '1;
        req_a = '0; req_b = '0; req_op = '0;

        // Reset state
        #12;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_y", rsp_y, 0);
        chk("rst_zero", 32'(rsp_zero), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic arithmetic and boundary ops
        do_op(1, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1'b0, "add_5_7");
        do_op(2, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0001, 32'd0, 1'b1, 1'b0, "sub_eq");
        do_op(2, 32'd0, 32'd1, 4'b0001, 32'hFFFFFFFF, 1'b0, 1'b0, "sub_wrap");
        do_op(0, 32'd9, 32'd3, 4'b0111, 32'd0, 1'b1, 1'b1, "illegal_op");
        do_op(0, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'd0, 1'b1, 1'b0, "add_wrap");

        // Backpressure on owner 0 while requester 1 waits; non-owner ready bits set
        rsp_ready = 3'b110;
        set_req(0, 32'd3, 32'd4, 4'b0000);
        wait_grant(0, "bp_grant0");
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 32'd20, 32'd3, 4'b0001);
        #1;
        chk("bp_exec_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_vld", 32'(rsp_valid), 32'b001);
            chk("bp_hold_y", rsp_y, 32'd7);
            chk("bp_hold_ready", 32'(req_ready), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 3'b111;
        #1;
        chk("bp_release_grant1", 32'(req_ready), 32'b010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        #1;
        chk("bp_exec2_vld", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("bp_rsp1_vld", 32'(rsp_valid), 32'b010);
        chk("bp_rsp1_y", rsp_y, 32'd17);
        @(posedge clk); #1;

        // Async reset while in EXEC
        set_req(2, 32'd1, 32'd1, 4'b0000);
        wait_grant(2, "rst_mid_grant");
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        chk("rst_mid_busy_pre", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_vld", 32'(rsp_valid), 0);
        chk("rst_mid_y", rsp_y, 0);
        chk("rst_mid_zero", 32'(rsp_zero), 0);
        chk("rst_mid_err", 32'(rsp_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_no_stray_vld", 32'(rsp_valid), 0);
            chk("rst_idle_busy", 32'(busy), 0);
        end

        // Round-robin fairness from reset: all three continuously valid
        for (int i = 0; i < NREQ; i++)
            set_req(i, 32'(100 * (i + 1)), 32'(i), 4'b0000);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 3)));
            if (k == 0) chk("rr_first_vld", 32'(rsp_valid), 0);
            else begin
                chk("rr_rsp_vld", 32'(rsp_valid), 32'(1 << ((k - 1) % 3)));
                chk("rr_rsp_y", rsp_y, 32'(100 * ((k - 1) % 3 + 1) + (k - 1) % 3));
            end
            @(posedge clk); #1;
            chk("rr_exec_ready", 32'(req_ready), 0);
            chk("rr_exec_vld", 32'(rsp_valid), 0);
            @(posedge clk); #1;
        end
        chk("rr_last_vld", 32'(rsp_valid), 32'b100);
        chk("rr_last_y", rsp_y, 32'd302);
        req_valid = '0;
        #1;
        chk("rr_end_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        chk("rr_end_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter that time-shares one instance of the team's 32-bit `alu` (ADD/SUB, zero flag) among `NREQ` requesters. Candidates include the fetch PC incrementer, the execute stage and the branch-compare unit. Each requester issues an operation over a valid/ready request channel and receives a registered result over a valid/ready response channel. The block sits between the CPU pipeline stages and the single shared ALU, and owns all sequencing of that ALU.

## Interface
- `NREQ`, default 3: number of requesters; legal range 2..8.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input NREQ: requester i has an operation pending.
- `req_ready` output NREQ: one-hot or zero; bit i means requester i's operation is accepted this cycle.
- `req_a` input NREQ×32: operand A per requester, packed as [i*32 +: 32].
- `req_b` input NREQ×32: operand B per requester.
- `req_op` input NREQ×4: ALU control per requester (0000 add, 0001 sub).
- `rsp_valid` output NREQ: one-hot or zero; result is available for requester i.
- `rsp_ready` input NREQ: requester i consumes its result.
- `rsp_y` output 32: result of the current response; shared across requesters and qualified by `rsp_valid`.
- `rsp_zero` output 1: ALU zero flag of the current response.
- `rsp_err` output 1: the op code of the current response was not 0000 or 0001.
- `busy` output 1: FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **Issue slot:** the slot is open in IDLE, and in RESP during the cycle the response handshake completes (`rsp_valid[o] & rsp_ready[o]`, where o is the owner).
- **Arbitration:** while the slot is open and any `req_valid` is set, grant exactly one requester, chosen by round-robin. Search starts at `rr_ptr` and wraps modulo NREQ. `req_ready[g]=1` combinationally in that cycle. All other `req_ready` bits are 0, and every bit is 0 while the slot is closed.
- **On accept:**
  - capture `req_a[g]`, `req_b[g]`, `req_op[g]` into operand registers;
  - set owner := g;
  - set `rr_ptr := (g+1) mod NREQ`;
  - go to EXEC.
- **EXEC:** the ALU sees only the operand registers. At the next edge, latch y, zero and err (`op ∉ {0000,0001}`) into response registers and go to RESP.
- **Unsupported op:** y=0 and zero=1, as produced by the ALU; `rsp_err=1`.
- **RESP:**
  - `rsp_valid[owner]=1` until `rsp_ready[owner]`.
  - If a new grant occurs in the handshake cycle, go to EXEC.
  - Otherwise go to IDLE.
- **rsp_ready masking:** `rsp_ready` bits of non-owners are ignored.
- **Ownership:** a requester with an outstanding response may be granted again only after its handshake completes. Same-cycle re-grant is allowed.
- **Request stability:** operand inputs must be stable only in the accept cycle. `req_valid` may drop without acceptance; no state is held for it.
- **Arithmetic:** modulo 2^32 with no carry or overflow outputs. SUB is a − b.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, owner=0, operand and response registers 0. Outputs: `req_ready`=0 (until combinational grant), `rsp_valid`=0, `rsp_y`=0, `rsp_zero`=0, `rsp_err`=0, `busy`=0.
- **Latency:** accept at edge N → `rsp_valid` high after edge N+1, i.e. 2 cycles.
- **Throughput:** with responses always consumed immediately, one operation every 2 cycles.
- **Simultaneous requests:** exactly one grant per open slot. Three simultaneous continuous requests from reset are granted in order 0,1,2,0,…
- **Response backpressure:** while `rsp_ready[owner]=0`, the FSM stays in RESP with `rsp_y`, `rsp_zero` and `rsp_err` stable, and all `req_ready` bits stay 0.
- **Reset mid-operation:** asynchronous return to reset values in any state. A pending response is discarded, and no `rsp_valid` follows.
- **No combinational path** from `rsp_ready` to `rsp_valid`. The only combinational paths are `req_valid` → `req_ready` and `rsp_ready` → `req_ready`.

## Structure
- **Package `alu_pkg`:**
  - `ALU_ADD=4'b0000` and `ALU_SUB=4'b0001` constants;
  - FSM state enum `arb_state_e` {IDLE, EXEC, RESP};
  - `ALU_W=32`.
- **Instances:** the existing `alu` is instantiated unmodified. Split out one sub-module, `rr_arbiter` (parameter N; inputs `req`, `ptr`, `en`; output one-hot `gnt`). It is reusable elsewhere.

## Test plan
- **Single ADD:** requester 1 sends a=5, b=7, op=0000 → `rsp_valid[1]` 2 cycles after accept, `rsp_y`=12, `rsp_zero`=0, `rsp_err`=0.
- **SUB to zero (BEQ path):** requester 2 sends a=b=0xDEADBEEF, op=0001 → `rsp_y`=0, `rsp_zero`=1; also check a=0, b=1 → `rsp_y`=0xFFFFFFFF.
- **Round-robin fairness:** all three requesters hold `req_valid` high continuously with `rsp_ready` high → grant order 0,1,2,0,1,2, one accept every 2 cycles, no starvation.
- **Backpressure:** hold `rsp_ready[0]`=0 for 5 cycles while requester 1 is valid → `rsp_y` is stable and `req_ready`=0 throughout. On release, requester 1 is granted in the handshake cycle.
- **Illegal op and wrap:** op=4'b0111 → `rsp_y`=0, `rsp_zero`=1, `rsp_err`=1. Also check a=0xFFFFFFFF, b=1, ADD → `rsp_y`=0, `rsp_zero`=1.
- **Async reset in EXEC:** deassert `rst_n` mid-operation → all outputs return to reset values immediately, no stray `rsp_valid` afterwards, and the first grant after reset goes to requester 0.
